alu1_sweep_driver: RTL

ALU1_SWEEP_DRIVER -- requirements
Module: alu1_sweep_driver

---
 rtl/alu1_sweep_driver_pkg.sv | 13 +
 rtl/alu1_sweep_driver_res_buf.sv | 30 +++
 rtl/alu1_sweep_driver.sv | 120 ++++++++++++
 3 files changed

// File: rtl/alu1_sweep_driver_pkg.sv
// Shared constants and FSM encoding for the alu1 opcode sweep driver and its bench.
package alu1_sweep_driver_pkg;

  localparam int SEL_W       = 2;
  localparam int NUM_OPS_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SEND = 2'd2
  } state_t;

endpackage

// File: rtl/alu1_sweep_driver_res_buf.sv
// Result buffer: one RES_W register per swept opcode. Write is synchronous, read is combinational.
// Clearing on reset means a discarded sweep never leaks stale results.
module alu1_res_buf
  import alu1_sweep_driver_pkg::*;
#(
  parameter int DEPTH = NUM_OPS_DEF,
  parameter int W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_idx,
  input  logic [W-1:0]     wr_dat,
  input  logic [SEL_W-1:0] rd_idx,
  output logic [W-1:0]     rd_dat
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/alu1_sweep_driver.sv
// Sweeps every alu1 opcode over one latched operand pair, buffers the results, then streams them out.
// The first result is valid NUM_OPS cycles after acceptance. res_ready low holds the current result.
module alu1_sweep_driver
  import alu1_sweep_driver_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int RES_W   = 8,
  parameter int NUM_OPS = NUM_OPS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_a,
  input  logic [OP_W-1:0]  cmd_b,
  output logic [SEL_W-1:0] alu_sel,
  output logic [OP_W-1:0]  alu_a,
  output logic [OP_W-1:0]  alu_b,
  input  logic [RES_W-1:0] alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SEL_W-1:0] res_sel,
  output logic [RES_W-1:0] res_data,
  output logic             busy
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_OPS - 1);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] cnt, cnt_nxt;
  logic [OP_W-1:0]  opa, opb;
  logic             cap_en;
  logic             last;
  logic [RES_W-1:0] buf_rd;

  assign last = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      opa   <= '0;
      opb   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == ST_IDLE && cmd_valid) begin
        opa <= cmd_a;
        opb <= cmd_b;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    res_sel   = '0;
    res_data  = '0;
    alu_sel   = '0;
    alu_a     = '0;
    alu_b     = '0;
    cap_en    = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          cnt_nxt   = '0;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        alu_sel = cnt;
        alu_a   = opa;
        alu_b   = opb;
        cap_en  = 1'b1;
        if (last) begin
          cnt_nxt   = '0;
          state_nxt = ST_SEND;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_SEND: begin
        res_valid = 1'b1;
        res_sel   = cnt;
        res_data  = buf_rd;
        if (res_ready) begin
          if (last) begin
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  alu1_res_buf #(
    .DEPTH (NUM_OPS),
    .W     (RES_W)
  ) u_res_buf (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (cap_en),
    .wr_idx (cnt),
    .wr_dat (alu_out),
    .rd_idx (cnt),
    .rd_dat (buf_rd)
  );

endmodule
